// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch front end: PC register, imem request/ack handshake, one-entry
// hold buffer and IF/ID register. Define STALL_COUNT_EN to add the stall_cycles counter.
module fetch_stage_ctrl #(
   parameter int unsigned          PC_W     = 16,
   parameter int unsigned          INSTR_W  = 16,
   parameter logic [PC_W-1:0]      RESET_PC = '0,
   parameter int unsigned          PC_INC   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pc_write,
   input  logic               ifid_write,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic               fetch_busy,
   output logic               state_dbg
`ifdef STALL_COUNT_EN
   ,
   output logic [15:0]        stall_cycles
`endif
);

   // Handshake: imem_req is held high in S_FETCH until a cycle with imem_ack=1;
   // that cycle transfers imem_rdata for address imem_addr. Acks without a request are ignored.
   typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]     ifid_pc_q, ifid_pc_d;
   logic                ifid_valid_q, ifid_valid_d;
   logic [INSTR_W-1:0]  hold_q, hold_d;
   logic                advance;
   logic [PC_W-1:0]     pc_next_seq;

   assign advance     = pc_write & ifid_write;
   assign pc_next_seq = pc_q + PC_W'(PC_INC);

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign fetch_busy = imem_req & ~imem_ack;
   assign pc         = pc_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_valid = ifid_valid_q;
   assign state_dbg  = state_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      hold_d       = hold_q;
      if (branch_taken) begin
         // Redirect beats stalls and discards any in-flight or buffered instruction.
         pc_d         = branch_target;
         ifid_valid_d = 1'b0;
         state_d      = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_ack) begin
                  if (advance) begin
                     ifid_instr_d = imem_rdata;
                     ifid_pc_d    = pc_q;
                     ifid_valid_d = 1'b1;
                     pc_d         = pc_next_seq;
                  end else begin
                     hold_d  = imem_rdata;
                     state_d = S_HOLD;
                  end
               end else if (advance) begin
                  ifid_valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               if (advance) begin
                  ifid_instr_d = hold_q;
                  ifid_pc_d    = pc_q;
                  ifid_valid_d = 1'b1;
                  pc_d         = pc_next_seq;
                  state_d      = S_FETCH;
               end
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
         hold_q       <= hold_d;
      end
   end

`ifdef STALL_COUNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((~advance | fetch_busy) && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed test-plan scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write, ifid_write, branch_taken, imem_ack;
   logic [15:0] branch_target, imem_rdata;
   logic        imem_req, ifid_valid, fetch_busy, state_dbg;
   logic [15:0] imem_addr, pc, ifid_instr, ifid_pc;
   logic        w_req, w_valid, w_busy, w_state;
   logic [15:0] w_addr, w_pc, w_instr, w_ipc;
`ifdef STALL_COUNT_EN
   logic [15:0] stall_cycles, w_stall;
`endif

   always #5 clk = ~clk;

   fetch_stage_ctrl dut (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .ifid_write(ifid_write),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
      .fetch_busy(fetch_busy), .state_dbg(state_dbg)
`ifdef STALL_COUNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   // Second instance shares stimulus; only used to observe PC wrap-around.
   fetch_stage_ctrl #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .ifid_write(ifid_write),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .pc(w_pc), .ifid_instr(w_instr), .ifid_pc(w_ipc), .ifid_valid(w_valid),
      .fetch_busy(w_busy), .state_dbg(w_state)
`ifdef STALL_COUNT_EN
      , .stall_cycles(w_stall)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: fetch PC, whether a fetched word is parked, and the IF/ID contents.
   logic [15:0] m_pc, m_hold, m_ii, m_ip;
   logic        m_parked, m_iv;
   int          m_stall;
   logic        l_busy, l_req;
   logic [15:0] l_addr;
   logic [15:0] exp_q[$];

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_hold = '0; m_ii = '0; m_ip = '0;
      m_parked = 1'b0; m_iv = 1'b0; m_stall = 0;
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, step model, check regs.
   task automatic cycle(input logic pw, input logic iw, input logic bt, input logic [15:0] tgt,
                        input logic ack, input logic [15:0] rd);
      logic adv, busy;
      pc_write = pw; ifid_write = iw; branch_taken = bt; branch_target = tgt;
      imem_ack = ack; imem_rdata = rd;
      #1;
      l_busy = fetch_busy; l_addr = imem_addr; l_req = imem_req;
      chk("imem_req", imem_req, !m_parked);
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_busy", fetch_busy, !m_parked && !ack);
      adv  = pw & iw;
      busy = !m_parked && !ack;
      if (!adv || busy) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (bt) begin
         m_pc = tgt; m_iv = 1'b0; m_parked = 1'b0;
      end else if (m_parked) begin
         if (adv) begin
            m_ii = m_hold; m_ip = m_pc; m_iv = 1'b1; m_pc = m_pc + 16'd2; m_parked = 1'b0;
         end
      end else if (ack) begin
         if (adv) begin
            m_ii = rd; m_ip = m_pc; m_iv = 1'b1; m_pc = m_pc + 16'd2;
         end else begin
            m_hold = rd; m_parked = 1'b1;
         end
      end else if (adv) begin
         m_iv = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("ifid_valid", ifid_valid, m_iv);
      chk("ifid_instr", ifid_instr, m_ii);
      chk("ifid_pc", ifid_pc, m_ip);
      chk("state_dbg", state_dbg, m_parked);
`ifdef STALL_COUNT_EN
      chk("stall_cycles", stall_cycles, m_stall[15:0]);
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; pc_write = 0; ifid_write = 0; branch_taken = 0; branch_target = 0;
      imem_ack = 0; imem_rdata = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] last_pc;
      do_reset();
      // Reset state
      chk("rst_pc", pc, 16'h0000);
      chk("rst_ifid_valid", ifid_valid, 0);
      chk("rst_ifid_instr", ifid_instr, 0);
      chk("rst_ifid_pc", ifid_pc, 0);
      chk("rst_imem_req", imem_req, 1);
      chk("rst_wrap_pc", w_pc, 16'hFFFE);

      // Zero-latency back-to-back fetches
      cycle(1, 1, 0, 0, 1, 16'hA001);
      chk("t1_instr0", ifid_instr, 16'hA001);
      chk("t1_pc0", ifid_pc, 16'h0000);
      chk("t1_valid0", ifid_valid, 1);
      chk("wrap_ifid_pc", w_ipc, 16'hFFFE);
      chk("wrap_pc", w_pc, 16'h0000);
      cycle(1, 1, 0, 0, 1, 16'hA002);
      chk("t1_pc1", ifid_pc, 16'h0002);
      cycle(1, 1, 0, 0, 1, 16'hA003);
      chk("t1_instr2", ifid_instr, 16'hA003);
      chk("t1_pc2", ifid_pc, 16'h0004);
      chk("t1_pc", pc, 16'h0006);

      // Load-use stall with ack: word parked, stray acks ignored, released once
      cycle(0, 0, 0, 0, 1, 16'hB00B);
      chk("t2_state", state_dbg, 1);
      cycle(0, 0, 0, 0, 1, 16'hEEEE);
      chk("t2_req", l_req, 0);
      cycle(1, 0, 0, 0, 1, 16'hEEEF);
      chk("t2_pc", pc, 16'h0006);
      chk("t2_ifid_hold", ifid_instr, 16'hA003);
      cycle(1, 1, 0, 0, 0, 16'h0000);
      chk("t2_instr", ifid_instr, 16'hB00B);
      chk("t2_ifid_pc", ifid_pc, 16'h0006);
      chk("t2_pc_rel", pc, 16'h0008);
      cycle(1, 1, 0, 0, 1, 16'hB00C);
      chk("t2_nodup_pc", ifid_pc, 16'h0008);

      // Two-cycle memory wait at pc=0x000A
      cycle(1, 1, 0, 0, 0, 16'h0000);
      chk("t3_busy0", l_busy, 1);
      chk("t3_bubble0", ifid_valid, 0);
      cycle(1, 1, 0, 0, 0, 16'h0000);
      chk("t3_busy1", l_busy, 1);
      chk("t3_addr", l_addr, 16'h000A);
      chk("t3_bubble1", ifid_valid, 0);
      cycle(1, 1, 0, 0, 1, 16'hC0DE);
      chk("t3_instr", ifid_instr, 16'hC0DE);
      chk("t3_ifid_pc", ifid_pc, 16'h000A);

      // Branch with ack and IF/ID stall: flush wins, data dropped
      cycle(1, 0, 1, 16'h0040, 1, 16'hDEAD);
      chk("t4_pc", pc, 16'h0040);
      chk("t4_valid", ifid_valid, 0);
      cycle(1, 1, 0, 0, 1, mem_f(16'h0040));
      chk("t4_next_addr", l_addr, 16'h0040);
      chk("t4_ifid_pc", ifid_pc, 16'h0040);

      // Randomized traffic; also checks every valid IF/ID entry pairs instr with its PC
      // and that consecutive loads are sequential unless redirected.
      last_pc = ifid_pc;
      exp_q.delete();
      for (int i = 0; i < 3000; i++) begin
         logic pw, iw, bt, ack;
         logic [15:0] rd;
         pw  = ($urandom_range(0, 9) < 8);
         iw  = ($urandom_range(0, 9) < 8);
         bt  = ($urandom_range(0, 15) == 0);
         ack = m_parked ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 1) == 1);
         rd  = m_parked ? 16'($urandom) : mem_f(m_pc);
         if (bt) exp_q.delete();
         else if (!m_parked && ack) exp_q.push_back(m_pc);
         cycle(pw, iw, bt, {$urandom_range(0, 16'h7FFF), 1'b0}, ack, rd);
         if (ifid_valid && (ifid_pc != last_pc || !pw || !iw)) begin
            chk("rnd_pair", ifid_instr, mem_f(ifid_pc));
         end
         if (pw && iw && !bt && ifid_valid && exp_q.size() > 0) begin
            chk("rnd_order", ifid_pc, exp_q.pop_front());
         end
         last_pc = ifid_pc;
      end

      // Asynchronous reset while a word is parked
      cycle(1, 1, 1, 16'h0100, 0, 16'h0000);
      cycle(0, 0, 0, 0, 1, mem_f(16'h0100));
      chk("t6_parked", state_dbg, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_pc", pc, 16'h0000);
      chk("t6_valid", ifid_valid, 0);
      chk("t6_state", state_dbg, 0);
      chk("t6_req", imem_req, 1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 1, 0, 0, 1, 16'h1234);
      chk("t6_after", ifid_instr, 16'h1234);

`ifdef STALL_COUNT_EN
      for (int i = 0; i < 70000; i++) cycle(0, 1, ($urandom_range(0, 999) == 0), 16'h0020, 0, 0);
      chk("t7_saturate", stall_cycles, 16'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
